cpu_out_capture: RTL and testbench
==================================

Name: cpu_out_capture

Overview:
- Downstream capture stage for the 8-bit cpu core output bus (`out`).
- Samples the cpu output on qualifying cycles and buffers the samples in a small FIFO that a host or bench drains with a read handshake.
- Keeps a running MISR signature of every accepted sample, so a whole run can be checked against a single byte.
- Flags lost samples with a sticky overflow bit.

Parameters:
WIDTH, 8, data width of captured samples (matches cpu out)
DEPTH, 8, FIFO entries (power of 2, >=2)
POLY, 8'h1D, MISR feedback polynomial (WIDTH bits)
SEED, 8'h00, MISR reset/clear value

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
cap_data  input  WIDTH  cpu out bus
cap_valid  input  1  sample qualifier for cap_data this cycle
cap_mode  input  1  0 = capture every valid sample; 1 = capture only when value differs from last accepted sample
clr  input  1  synchronous clear of FIFO, signature, overflow, change history
rd_en  input  1  read request
rd_data  output  WIDTH  read data, registered
rd_valid  output  1  one-cycle pulse: rd_data holds a popped entry
count  output  log2(DEPTH)+1  current occupancy
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: an accepted-qualifying sample was dropped
sig  output  WIDTH  MISR signature

Behaviour:
- Reset (reset=0, async): rd_data=0, rd_valid=0, count=0, empty=1, full=0, overflow=0, sig=SEED, write/read pointers=0, change history cleared. All outputs are registered; full/empty/count are derived from registered state.
- Qualify (capture request, cap_req):
  - cap_mode=0: cap_req = cap_valid.
  - cap_mode=1: cap_req = cap_valid & (!have_last | cap_data != last).
  - have_last is set by the first accepted write. last updates only on accepted writes.
- Write accept: cap_req & (!full | rd_pop).
  - An accepted write stores cap_data at wr_ptr, and wr_ptr wraps modulo DEPTH.
  - Same edge, MISR update: sig <= ({sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0)) ^ cap_data.
- Drop: cap_req & full & !rd_pop. The entry is not written, sig is unchanged, overflow <= 1. overflow stays set until reset or clr.
- Read: rd_pop = rd_en & !empty.
  - On a pop, rd_data <= mem[rd_ptr] at the edge, rd_valid=1 for exactly the next cycle, and rd_ptr wraps.
  - rd_en while empty: ignored, rd_valid=0, rd_data holds its previous value. There is no write-to-read bypass; a sample written while empty is readable from the next cycle.
- Simultaneous push and pop: count unchanged; accepted when full (the pop frees a slot).
- Latency: cap_data to readable = 1 cycle; rd_en to rd_data/rd_valid = 1 cycle.
- clr=1 (sync, highest priority):
  - Pointers and count go to 0, overflow=0, sig=SEED, have_last=0, rd_valid=0. rd_data is held.
  - Same-cycle cap_req and rd_en are ignored.
- Reset mid-operation: all state is lost immediately, with no partial write.

Test Plan:
- Reset then write 8'h6F, 8'hA5, 8'h3C (cap_mode=0, one per cycle) -> sig 8'h6F, 8'h7B, 8'hCA after each edge; count=3.
- Fill 8 entries, 9th cap_valid with no read -> full=1, count=8, overflow=1, sig unchanged by the 9th. Drain 8 reads -> the first 8 values in order, rd_valid one cycle each, empty=1.
- Full with cap_valid & rd_en in the same cycle -> write accepted, oldest popped, count stays 8, overflow stays 0.
- cap_mode=1, cap_data sequence 11,11,22,22,11 all valid -> 3 entries (11,22,11). rd_en while empty -> rd_valid stays 0.
- Pointer wrap: 20 interleaved write/read pairs -> data returned in FIFO order across wrap, count never exceeds 1.
- Mid-stream: clr with cap_valid=1 -> count=0, sig=SEED, overflow=0, no entry written. reset=0 pulsed asynchronously between edges -> outputs go to reset values immediately.

Source files
------------

// File: rtl/cpu_out_capture.sv
`default_nettype none
// ============================================================================
// Module   : cpu_out_capture
// Purpose  : Capture stage for the cpu core output bus. Qualifies samples
//            (every valid, or only on value change), buffers them in a small
//            FIFO drained by a read handshake, keeps a MISR signature of all
//            accepted samples and raises a sticky overflow on dropped samples.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_out_capture #(
  parameter int unsigned           WIDTH = 8,
  parameter int unsigned           DEPTH = 8,
  parameter logic [WIDTH-1:0]      POLY  = 8'h1D,
  parameter logic [WIDTH-1:0]      SEED  = 8'h00
) (
  input  logic                         clk,
  input  logic                         reset,      // async, active-low
  input  logic [WIDTH-1:0]             cap_data,
  input  logic                         cap_valid,
  input  logic                         cap_mode,
  input  logic                         clr,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         rd_valid,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic [WIDTH-1:0]             sig
);

  localparam int unsigned      c_aw    = $clog2(DEPTH);
  localparam int unsigned      c_cw    = c_aw + 1;
  localparam logic [c_cw-1:0]  c_depth = c_cw'(DEPTH);
  localparam logic [c_aw-1:0]  c_one_p = c_aw'(1);
  localparam logic [c_cw-1:0]  c_one_c = c_cw'(1);

  // Storage and state
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_overflow;
  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] r_last;
  logic             r_have_last;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  // Combinational decode
  logic             w_cap_req;
  logic             w_rd_pop;
  logic             w_wr_acc;
  logic             w_drop;
  logic [c_cw-1:0]  w_count_next;
  logic [WIDTH-1:0] w_sig_next;

  // Qualify the sample, then decide accept/drop/pop for this cycle
  always_comb begin
    w_cap_req = cap_valid & (~cap_mode | ~r_have_last | (cap_data != r_last));
    w_rd_pop  = rd_en & ~r_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    w_wr_acc  = w_cap_req & (~r_full | w_rd_pop);
    w_drop    = w_cap_req & r_full & ~w_rd_pop;
  end

  // Next occupancy from the push/pop pair
  always_comb begin
    w_count_next = r_count;
    unique case ({w_wr_acc, w_rd_pop})
      2'b10:   w_count_next = r_count + c_one_c;
      2'b01:   w_count_next = r_count - c_one_c;
      default: w_count_next = r_count;
    endcase
  end

  // MISR step: shift left, fold the polynomial on carry-out, xor in the sample
  always_comb begin
    w_sig_next = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ cap_data;
  end

  // FIFO storage write; cleared on reset so no partial write survives it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (!clr && w_wr_acc) begin
      r_mem[r_wr_ptr] <= cap_data;
    end
  end

  // Pointers, occupancy and registered full/empty flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_one_p;
      if (w_rd_pop) r_rd_ptr <= r_rd_ptr + c_one_p;
      r_count <= w_count_next;
      r_full  <= (w_count_next == c_depth);
      r_empty <= (w_count_next == '0);
    end
  end

  // Signature, change history and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sig       <= SEED;
      r_last      <= '0;
      r_have_last <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (clr) begin
      r_sig       <= SEED;
      r_have_last <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_sig       <= w_sig_next;
        r_last      <= cap_data;
        r_have_last <= 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Read port: registered data, one-cycle valid pulse per pop; data held otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (clr) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_pop;
      if (w_rd_pop) r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign count    = r_count;
  assign full     = r_full;
  assign empty    = r_empty;
  assign overflow = r_overflow;
  assign sig      = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_cpu_out_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_out_capture
// Purpose  : Directed self-checking bench for cpu_out_capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_out_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cap_data;
  logic       cap_valid;
  logic       cap_mode;
  logic       clr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] sig;

  int n_vec = 0;
  int n_err = 0;

  cpu_out_capture #(.WIDTH(8), .DEPTH(8), .POLY(8'h1D), .SEED(8'h00)) dut (
    .clk(clk), .reset(reset), .cap_data(cap_data), .cap_valid(cap_valid),
    .cap_mode(cap_mode), .clr(clr), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .sig(sig)
  );

  always #5 clk = ~clk;

  // Reference MISR step
  function automatic logic [7:0] misr(input logic [7:0] s, input logic [7:0] d);
    logic [7:0] t;
    t = {s[6:0], 1'b0};
    if (s[7]) t = t ^ 8'h1D;
    return t ^ d;
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cap_valid = 1'b0; rd_en = 1'b0; clr = 1'b0; cap_mode = 1'b0; cap_data = 8'h00;
  endtask

  task automatic do_clr();
    idle(); clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b0;
    step(); step();
    n_vec++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_vec++; if (count !== 4'd0)    begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_vec++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reset_flags got e%b f%b want e1 f0", empty, full); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_vec++; if (sig !== 8'h00)     begin n_err++; $display("FAIL reset_sig got %h want 00", sig); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_misr();
    logic [7:0] d [3];
    logic [7:0] e [3];
    d = '{8'h6F, 8'hA5, 8'h3C};
    e = '{8'h6F, 8'h7B, 8'hCA};
    idle();
    for (int i = 0; i < 3; i++) begin
      cap_valid = 1'b1; cap_data = d[i];
      step();
      n_vec++; if (sig !== e[i]) begin n_err++; $display("FAIL misr_sig%0d got %h want %h", i, sig, e[i]); end
    end
    idle();
    n_vec++; if (count !== 4'd3) begin n_err++; $display("FAIL misr_count got %0d want 3", count); end
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL misr_empty got %b want 0", empty); end
    do_clr();
  endtask

  task automatic test_fill_overflow();
    logic [7:0] v [8];
    logic [7:0] s;
    s = 8'h00;
    idle();
    for (int i = 0; i < 8; i++) begin
      v[i] = 8'(8'h13 + i * 8'h29);
      cap_valid = 1'b1; cap_data = v[i];
      s = misr(s, v[i]);
      step();
    end
    n_vec++; if (count !== 4'd8 || full !== 1'b1) begin n_err++; $display("FAIL fill_full got c%0d f%b want c8 f1", count, full); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_ovf_early got %b want 0", overflow); end
    n_vec++; if (sig !== s) begin n_err++; $display("FAIL fill_sig got %h want %h", sig, s); end
    cap_data = 8'hF0;
    step();
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL drop_ovf got %b want 1", overflow); end
    n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL drop_count got %0d want 8", count); end
    n_vec++; if (sig !== s) begin n_err++; $display("FAIL drop_sig got %h want %h", sig, s); end
    idle(); rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_vec++; if (rd_valid !== 1'b1 || rd_data !== v[i]) begin n_err++; $display("FAIL drain%0d got v%b %h want v1 %h", i, rd_valid, rd_data, v[i]); end
    end
    rd_en = 1'b0;
    step();
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL drain_pulse got %b want 0", rd_valid); end
    n_vec++; if (empty !== 1'b1 || count !== 4'd0) begin n_err++; $display("FAIL drain_empty got e%b c%0d want e1 c0", empty, count); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    do_clr();
  endtask

  task automatic test_full_simul();
    idle();
    for (int i = 0; i < 8; i++) begin
      cap_valid = 1'b1; cap_data = 8'(8'h80 + i);
      step();
    end
    cap_data = 8'hEE; rd_en = 1'b1;
    step();
    idle();
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'h80) begin n_err++; $display("FAIL simul_pop got v%b %h want v1 80", rd_valid, rd_data); end
    n_vec++; if (count !== 4'd8 || full !== 1'b1) begin n_err++; $display("FAIL simul_count got c%0d f%b want c8 f1", count, full); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL simul_ovf got %b want 0", overflow); end
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_vec++; if (rd_data !== ((i == 7) ? 8'hEE : 8'(8'h81 + i))) begin n_err++; $display("FAIL simul_drain%0d got %h", i, rd_data); end
    end
    do_clr();
  endtask

  task automatic test_change_mode();
    logic [7:0] d [5];
    logic [7:0] e [3];
    d = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h11};
    e = '{8'h11, 8'h22, 8'h11};
    idle(); cap_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cap_valid = 1'b1; cap_data = d[i];
      step();
    end
    cap_valid = 1'b0;
    n_vec++; if (count !== 4'd3) begin n_err++; $display("FAIL chg_count got %0d want 3", count); end
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (rd_valid !== 1'b1 || rd_data !== e[i]) begin n_err++; $display("FAIL chg_rd%0d got v%b %h want v1 %h", i, rd_valid, rd_data, e[i]); end
    end
    step();
    n_vec++; if (rd_valid !== 1'b0 || rd_data !== 8'h11) begin n_err++; $display("FAIL empty_rd got v%b %h want v0 11", rd_valid, rd_data); end
    do_clr();
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    idle();
    for (int i = 0; i < 20; i++) begin
      d = 8'(8'hC1 ^ (i * 7));
      cap_valid = 1'b1; cap_data = d; rd_en = 1'b0;
      step();
      n_vec++; if (count !== 4'd1) begin n_err++; $display("FAIL wrap_cnt%0d got %0d want 1", i, count); end
      cap_valid = 1'b0; rd_en = 1'b1;
      step();
      n_vec++; if (rd_valid !== 1'b1 || rd_data !== d || count !== 4'd0) begin n_err++; $display("FAIL wrap_rd%0d got v%b %h c%0d want v1 %h c0", i, rd_valid, rd_data, count, d); end
    end
    do_clr();
  endtask

  task automatic test_clr();
    idle();
    for (int i = 0; i < 9; i++) begin
      cap_valid = 1'b1; cap_data = 8'(8'h40 + i);
      step();
    end
    rd_en = 1'b1; cap_valid = 1'b0;
    step();
    n_vec++; if (rd_data !== 8'h40 || overflow !== 1'b1) begin n_err++; $display("FAIL preclr got %h o%b want 40 o1", rd_data, overflow); end
    clr = 1'b1; cap_valid = 1'b1; cap_data = 8'h55; rd_en = 1'b1;
    step();
    idle();
    n_vec++; if (count !== 4'd0 || empty !== 1'b1) begin n_err++; $display("FAIL clr_count got c%0d e%b want c0 e1", count, empty); end
    n_vec++; if (sig !== 8'h00 || overflow !== 1'b0) begin n_err++; $display("FAIL clr_sig got %h o%b want 00 o0", sig, overflow); end
    n_vec++; if (rd_valid !== 1'b0 || rd_data !== 8'h40) begin n_err++; $display("FAIL clr_rd got v%b %h want v0 40", rd_valid, rd_data); end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL clr_nowrite got %b want 0", rd_valid); end
  endtask

  task automatic test_async_reset();
    idle();
    for (int i = 0; i < 3; i++) begin
      cap_valid = 1'b1; cap_data = 8'(8'h90 + i);
      step();
    end
    idle(); rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_vec++; if (count !== 4'd0 || empty !== 1'b1) begin n_err++; $display("FAIL arst_count got c%0d e%b want c0 e1", count, empty); end
    n_vec++; if (sig !== 8'h00 || rd_data !== 8'h00 || rd_valid !== 1'b0) begin n_err++; $display("FAIL arst_out got s%h d%h v%b want s00 d00 v0", sig, rd_data, rd_valid); end
    #1;
    reset = 1'b1;
    step();
    n_vec++; if (count !== 4'd0 || sig !== 8'h00) begin n_err++; $display("FAIL arst_after got c%0d s%h want c0 s00", count, sig); end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_misr();
    test_fill_overflow();
    test_full_simul();
    test_change_mode();
    test_wrap();
    test_clr();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
`default_nettype wire
